tlb_op_controller: RTL and testbench
====================================

# tlb_op_controller

Sequences the multi-cycle TLB instructions (TLBP, TLBR, TLBWI) that the write-back stage hands to CP0 via its tlb_read / tlb_write / tlb_probe flags. It holds the pipeline with a busy stall while an operation runs, and scans the TLB tag array one entry per cycle for probes. It drives the TLB's index and read/write strobes and returns probe results to CP0 Index. Pending operations are aborted cleanly on an exception or ERET flush.

## Interface
- TLB_ENTRIES, 16: number of TLB entries; power of two, 2..64.
- INDEX_WIDTH, $clog2(TLB_ENTRIES): index width.

- clock  in  1  system clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  WB presents a TLB instruction; held high while busy.
- op_probe / op_read / op_write  in  1 each  operation select from WB.
- flush  in  1  exception_valid or eret_flush from WB; aborts the operation.
- index_value  in  INDEX_WIDTH  CP0 Index.Index field.
- entry_hi_vpn2  in  19  CP0 EntryHi.VPN2.
- entry_hi_asid  in  8  CP0 EntryHi.ASID.
- tlb_index  out  INDEX_WIDTH  entry address to the TLB arrays.
- tlb_entry_vpn2  in  19  tag of entry tlb_index, combinational read.
- tlb_entry_asid  in  8  ASID of entry tlb_index, combinational read.
- tlb_entry_global  in  1  G bit of entry tlb_index, combinational read.
- tlb_read_enable  out  1  CP0 captures entry tlb_index into EntryHi/Lo0/Lo1 at this edge.
- tlb_write_enable  out  1  TLB writes EntryHi/Lo0/Lo1 into entry tlb_index at this edge.
- busy  out  1  stall request to WB and earlier stages.
- op_done  out  1  one-cycle pulse when the operation completes.
- probe_hit  out  1  result of the last probe; valid during op_done.
- probe_index  out  INDEX_WIDTH  matching entry of the last probe.

## Operation
- States: IDLE, PROBE, READ, WRITE, DONE.
- IDLE: if op_valid && !flush, accept the operation:
  - latch index_value, entry_hi_vpn2 and entry_hi_asid;
  - priority when several select bits are set: probe > read > write;
  - go to PROBE (counter = 0), READ or WRITE;
  - op_valid with no select bit set: stay IDLE, busy stays low.
- PROBE:
  - tlb_index = counter;
  - match = (tlb_entry_vpn2 == latched vpn2) && (tlb_entry_global || tlb_entry_asid == latched asid);
  - on match: probe_hit <= 1, probe_index <= counter, go to DONE;
  - else if counter == TLB_ENTRIES-1: probe_hit <= 0, probe_index <= 0, go to DONE;
  - else counter increments;
  - lowest matching index wins.
- READ: tlb_index = latched index; tlb_read_enable = 1 for exactly one cycle; go to DONE.
- WRITE: tlb_index = latched index; tlb_write_enable = 1 for exactly one cycle; go to DONE.
- DONE: op_done = 1, busy = 0, go to IDLE. No new operation is accepted in DONE, because WB retires the instruction on this edge.
- busy = (state == IDLE && op_valid && any select bit && !flush) || state in {PROBE, READ, WRITE}.
- flush in PROBE / READ / WRITE:
  - go to IDLE next edge, with no op_done;
  - tlb_read_enable and tlb_write_enable are gated low in that cycle;
  - probe_hit and probe_index keep their previous values.
- flush in DONE: completion stands; go to IDLE.
- tlb_index = 0 in IDLE and DONE.

## Timing
- Reset (asynchronous assert) state: IDLE, counter 0, probe_hit 0, probe_index 0, op_done 0, enables 0, latched fields 0. busy then follows op_valid combinationally.
- Read / write latency: accept edge, then one READ/WRITE cycle, then one DONE cycle. busy is high for 2 cycles.
- Probe hitting entry k: k+1 PROBE cycles, then DONE. busy is high for k+2 cycles.
- Probe miss: TLB_ENTRIES PROBE cycles, then DONE.
- The counter never wraps: scanning stops at TLB_ENTRIES-1.
- Reset deasserted mid-operation: no spurious op_done or write strobe.

## Test plan
- Probe hit: entry 5 holds vpn2 0x12345, asid 0x07, G=0; EntryHi = 0x12345 / 0x07 -> 6 PROBE cycles, op_done with probe_hit 1, probe_index 5; busy high for 7 cycles.
- Global match and miss:
  - entry 9 holds vpn2 0x00ABC, G=1, asid 0x01; probe with asid 0x3F -> hit, index 9;
  - repeat with G=0 -> 16 PROBE cycles, probe_hit 0, probe_index 0.
- Duplicate match: entries 2 and 11 both match -> probe_index 2.
- Read / write: Index = 3, TLBR -> tlb_read_enable for one cycle with tlb_index 3, op_done the next cycle. TLBWI with Index = 14 -> tlb_write_enable for one cycle with tlb_index 14.
- Flush abort:
  - TLBWI with flush asserted in the WRITE cycle -> tlb_write_enable stays 0, no op_done, IDLE next cycle;
  - flush during PROBE cycle 3 -> IDLE, previous probe_hit / probe_index retained.
- Reset: assert reset_n = 0 during PROBE cycle 4 -> state IDLE immediately, all outputs at reset values; after release, a TLBR to index 1 completes normally.

Source files
------------

// File: rtl/tlb_op_if.sv
// tlb_op_if: WB/CP0/TLB-array signal bundle for the TLB operation controller.
//   op_valid/op_probe/op_read/op_write/flush : instruction request and abort from WB
//   index_value/entry_hi_vpn2/entry_hi_asid  : CP0 Index and EntryHi fields
//   tlb_index/tlb_entry_*                    : TLB array address and combinational tag read
//   tlb_read_enable/tlb_write_enable         : capture / write strobes
//   busy/op_done/probe_hit/probe_index       : stall, completion pulse and probe result
interface tlb_op_if #(
    parameter int INDEX_WIDTH = 4
);
    logic                   op_valid;
    logic                   op_probe;
    logic                   op_read;
    logic                   op_write;
    logic                   flush;
    logic [INDEX_WIDTH-1:0] index_value;
    logic [18:0]            entry_hi_vpn2;
    logic [7:0]             entry_hi_asid;
    logic [INDEX_WIDTH-1:0] tlb_index;
    logic [18:0]            tlb_entry_vpn2;
    logic [7:0]             tlb_entry_asid;
    logic                   tlb_entry_global;
    logic                   tlb_read_enable;
    logic                   tlb_write_enable;
    logic                   busy;
    logic                   op_done;
    logic                   probe_hit;
    logic [INDEX_WIDTH-1:0] probe_index;

    modport slave (
        input  op_valid, op_probe, op_read, op_write, flush,
        input  index_value, entry_hi_vpn2, entry_hi_asid,
        input  tlb_entry_vpn2, tlb_entry_asid, tlb_entry_global,
        output tlb_index, tlb_read_enable, tlb_write_enable,
        output busy, op_done, probe_hit, probe_index
    );

    modport master (
        output op_valid, op_probe, op_read, op_write, flush,
        output index_value, entry_hi_vpn2, entry_hi_asid,
        output tlb_entry_vpn2, tlb_entry_asid, tlb_entry_global,
        input  tlb_index, tlb_read_enable, tlb_write_enable,
        input  busy, op_done, probe_hit, probe_index
    );
endinterface

// File: rtl/tlb_op_controller.sv
// tlb_op_controller: sequences TLBP/TLBR/TLBWI, stalling WB while an operation runs.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   io_bus  : tlb_op_if slave (request from WB, CP0 fields, TLB array port, results)
module tlb_op_controller #(
    parameter int TLB_ENTRIES = 16,
    parameter int INDEX_WIDTH = $clog2(TLB_ENTRIES)
) (
    input logic     i_clk,
    input logic     i_rst_n,
    tlb_op_if.slave io_bus
);
    localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(TLB_ENTRIES - 1);

    typedef enum logic [2:0] {S_IDLE, S_PROBE, S_READ, S_WRITE, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [INDEX_WIDTH-1:0] r_counter;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [18:0]            r_vpn2;
    logic [7:0]             r_asid;
    logic                   r_probe_hit;
    logic [INDEX_WIDTH-1:0] r_probe_index;
    logic                   w_accept;
    logic                   w_match;
    logic                   w_last;
    logic                   w_probing;

    assign w_accept  = r_state == S_IDLE && io_bus.op_valid && !io_bus.flush &&
                       (io_bus.op_probe || io_bus.op_read || io_bus.op_write);
    assign w_match   = io_bus.tlb_entry_vpn2 == r_vpn2 &&
                       (io_bus.tlb_entry_global || io_bus.tlb_entry_asid == r_asid);
    assign w_last    = r_counter == LAST;
    // A flushed probe cycle must neither advance the scan nor publish a result.
    assign w_probing = r_state == S_PROBE && !io_bus.flush;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:          w_next = !w_accept ? S_IDLE : io_bus.op_probe ? S_PROBE :
                                      io_bus.op_read ? S_READ : S_WRITE;
            S_PROBE:         w_next = io_bus.flush ? S_IDLE : (w_match || w_last) ? S_DONE : S_PROBE;
            S_READ, S_WRITE: w_next = io_bus.flush ? S_IDLE : S_DONE;
            default:         w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_counter     <= '0;
            r_index       <= '0;
            r_vpn2        <= '0;
            r_asid        <= '0;
            r_probe_hit   <= 1'b0;
            r_probe_index <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_counter <= '0;
                r_index   <= io_bus.index_value;
                r_vpn2    <= io_bus.entry_hi_vpn2;
                r_asid    <= io_bus.entry_hi_asid;
            end else if (w_probing && !w_match && !w_last) begin
                r_counter <= r_counter + 1'b1;
            end
            if (w_probing && (w_match || w_last)) begin
                r_probe_hit   <= w_match;
                r_probe_index <= w_match ? r_counter : '0;
            end
        end
    end

    assign io_bus.tlb_index        = r_state == S_PROBE ? r_counter :
                                     (r_state == S_READ || r_state == S_WRITE) ? r_index : '0;
    assign io_bus.tlb_read_enable  = r_state == S_READ && !io_bus.flush;
    assign io_bus.tlb_write_enable = r_state == S_WRITE && !io_bus.flush;
    assign io_bus.busy             = w_accept || r_state == S_PROBE || r_state == S_READ ||
                                     r_state == S_WRITE;
    assign io_bus.op_done          = r_state == S_DONE;
    assign io_bus.probe_hit        = r_probe_hit;
    assign io_bus.probe_index      = r_probe_index;
endmodule

// File: tb/tb_tlb_op_controller.sv
// tb_tlb_op_controller: directed and randomized TLBP/TLBR/TLBWI checks against a TLB array model.
module tb_tlb_op_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [18:0] t_vpn [16];
    logic [7:0]  t_asid[16];
    logic        t_g   [16];
    logic        m_hit = 1'b0;
    int          m_idx = 0;

    tlb_op_if #(.INDEX_WIDTH(4)) bus ();

    tlb_op_controller #(.TLB_ENTRIES(16)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.tlb_entry_vpn2   = t_vpn[bus.tlb_index];
        bus.tlb_entry_asid   = t_asid[bus.tlb_index];
        bus.tlb_entry_global = t_g[bus.tlb_index];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tlb();
        for (int e = 0; e < 16; e++) begin
            t_vpn[e]  = 19'(32'h40000 + e);
            t_asid[e] = 8'h00;
            t_g[e]    = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        bus.op_valid = 1'b0;
        bus.op_probe = 1'b0;
        bus.op_read  = 1'b0;
        bus.op_write = 1'b0;
        bus.flush    = 1'b0;
    endtask

    // flush_at: 1..n = flush in that working cycle, n+1 = flush in DONE, 0 = none
    task automatic do_op(input bit pr, input bit rd, input bit wr, input int idx,
                         input logic [18:0] vpn, input logic [7:0] asid, input int flush_at);
        int kind;
        int k;
        int n_work;
        int busy_n;
        kind = pr ? 1 : rd ? 2 : 3;
        k = -1;
        if (kind == 1)
            for (int e = 0; e < 16; e++)
                if (k < 0 && t_vpn[e] == vpn && (t_g[e] || t_asid[e] == asid)) k = e;
        n_work = kind != 1 ? 1 : k >= 0 ? k + 1 : 16;
        bus.op_valid      = 1'b1;
        bus.op_probe      = pr;
        bus.op_read       = rd;
        bus.op_write      = wr;
        bus.index_value   = 4'(idx);
        bus.entry_hi_vpn2 = vpn;
        bus.entry_hi_asid = asid;
        bus.flush         = 1'b0;
        #1;
        chk("accept_busy", 32'(bus.busy), 1);
        chk("accept_index", 32'(bus.tlb_index), 0);
        busy_n = 1;
        for (int c = 1; c <= n_work; c++) begin
            @(posedge clk); #1;
            bus.index_value   = 4'($urandom);
            bus.entry_hi_vpn2 = 19'($urandom);
            bus.entry_hi_asid = 8'($urandom);
            if (c == flush_at) bus.flush = 1'b1;
            #1;
            busy_n += int'(bus.busy);
            chk("work_done", 32'(bus.op_done), 0);
            chk("work_index", 32'(bus.tlb_index), kind == 1 ? c - 1 : idx);
            chk("read_en", 32'(bus.tlb_read_enable), 32'(kind == 2 && c != flush_at));
            chk("write_en", 32'(bus.tlb_write_enable), 32'(kind == 3 && c != flush_at));
            if (c == flush_at) begin
                @(posedge clk); #1;
                idle_inputs();
                #1;
                chk("abort_done", 32'(bus.op_done), 0);
                chk("abort_busy", 32'(bus.busy), 0);
                chk("abort_hit", 32'(bus.probe_hit), 32'(m_hit));
                chk("abort_pidx", 32'(bus.probe_index), m_idx);
                chk("abort_busy_cycles", busy_n, c + 1);
                return;
            end
        end
        @(posedge clk); #1;
        if (flush_at == n_work + 1) bus.flush = 1'b1;
        #1;
        chk("busy_cycles", busy_n, n_work + 1);
        chk("done_pulse", 32'(bus.op_done), 1);
        chk("done_busy", 32'(bus.busy), 0);
        chk("done_index", 32'(bus.tlb_index), 0);
        chk("done_en", 32'({bus.tlb_read_enable, bus.tlb_write_enable}), 0);
        if (kind == 1) begin
            m_hit = k >= 0;
            m_idx = k >= 0 ? k : 0;
        end
        chk("probe_hit", 32'(bus.probe_hit), 32'(m_hit));
        chk("probe_index", 32'(bus.probe_index), m_idx);
        idle_inputs();
        @(posedge clk); #1;
        chk("after_done", 32'(bus.op_done), 0);
        chk("after_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        idle_inputs();
        bus.index_value   = '0;
        bus.entry_hi_vpn2 = '0;
        bus.entry_hi_asid = '0;
        clear_tlb();
        #12;
        chk("rst_done", 32'(bus.op_done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_hit", 32'(bus.probe_hit), 0);
        chk("rst_pidx", 32'(bus.probe_index), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        t_vpn[5] = 19'h12345; t_asid[5] = 8'h07;
        do_op(1, 0, 0, 0, 19'h12345, 8'h07, 0);
        t_vpn[9] = 19'h00ABC; t_asid[9] = 8'h01; t_g[9] = 1'b1;
        do_op(1, 0, 0, 0, 19'h00ABC, 8'h3F, 0);
        t_g[9] = 1'b0;
        do_op(1, 0, 0, 0, 19'h00ABC, 8'h3F, 0);
        clear_tlb();
        t_vpn[2] = 19'h55555; t_asid[2] = 8'h10;
        t_vpn[11] = 19'h55555; t_asid[11] = 8'h10;
        do_op(1, 0, 0, 0, 19'h55555, 8'h10, 0);
        do_op(0, 1, 0, 3, 19'h0, 8'h0, 0);
        do_op(0, 0, 1, 14, 19'h0, 8'h0, 0);
        do_op(1, 1, 1, 6, 19'h55555, 8'h10, 0);
        do_op(0, 1, 1, 7, 19'h0, 8'h0, 0);
        do_op(0, 0, 1, 14, 19'h0, 8'h0, 1);
        do_op(0, 1, 0, 4, 19'h0, 8'h0, 1);
        do_op(1, 0, 0, 0, 19'h7FFFF, 8'h00, 3);
        do_op(0, 1, 0, 9, 19'h0, 8'h0, 2);
        bus.op_valid = 1'b1;
        #1;
        chk("nosel_busy", 32'(bus.busy), 0);
        @(posedge clk); #1;
        chk("nosel_done", 32'(bus.op_done), 0);
        chk("nosel_index", 32'(bus.tlb_index), 0);
        idle_inputs();
        bus.op_valid = 1'b1;
        bus.op_read  = 1'b1;
        bus.flush    = 1'b1;
        #1;
        chk("flush_blocks_accept", 32'(bus.busy), 0);
        idle_inputs();
        @(posedge clk); #1;
        bus.op_valid      = 1'b1;
        bus.op_probe      = 1'b1;
        bus.entry_hi_vpn2 = 19'h7FFFF;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_index", 32'(bus.tlb_index), 3);
        rst_n = 1'b0;
        bus.op_probe = 1'b0;
        bus.op_read  = 1'b1;
        #1;
        chk("rst_busy_follows", 32'(bus.busy), 1);
        idle_inputs();
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_done", 32'(bus.op_done), 0);
        chk("mid_rst_index", 32'(bus.tlb_index), 0);
        chk("mid_rst_en", 32'({bus.tlb_read_enable, bus.tlb_write_enable}), 0);
        chk("mid_rst_hit", 32'(bus.probe_hit), 0);
        chk("mid_rst_pidx", 32'(bus.probe_index), 0);
        m_hit = 1'b0;
        m_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", 32'(bus.op_done), 0);
        do_op(0, 1, 0, 1, 19'h0, 8'h0, 0);
        for (int r = 0; r < 40; r++) begin
            int sel;
            for (int e = 0; e < 16; e++) begin
                t_vpn[e]  = 19'($urandom_range(0, 11));
                t_asid[e] = 8'($urandom_range(0, 3));
                t_g[e]    = $urandom_range(0, 3) == 0;
            end
            sel = $urandom_range(1, 7);
            do_op(sel[2], sel[1], sel[0], $urandom_range(0, 15), 19'($urandom_range(0, 11)),
                  8'($urandom_range(0, 3)), $urandom_range(0, 3) == 0 ? $urandom_range(1, 6) : 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
